// File: rtl/hive_alu_mux_pipe_pkg.sv
// Shared widths, packed stage-index tables and select helpers for the ALU result mux pipeline.
package hive_alu_mux_pipe_pkg;

  localparam int ALU_W_DEF = 32;
  localparam int FLG_W_DEF = 4;
  localparam int STG_W     = 8;
  localparam int SRC_MAX   = 16;

  // One STG_W-bit stage index per source, source k at bits [k*STG_W +: STG_W].
  typedef logic [SRC_MAX*STG_W-1:0] stg_arr_t;

  localparam stg_arr_t SRC_STG_DEF = stg_arr_t'({8'd5, 8'd4, 8'd3, 8'd3, 8'd3, 8'd3});
  localparam stg_arr_t FLG_STG_DEF = stg_arr_t'({8'd6, 8'd4, 8'd3, 8'd3, 8'd3, 8'd3});

  function automatic logic [STG_W-1:0] stg_get(input stg_arr_t arr, input int k);
    return arr[k*STG_W +: STG_W];
  endfunction

  // True when at most one bit of the select is set.
  function automatic logic onehot_chk(input logic [SRC_MAX-1:0] vec);
    return ((vec & (vec - SRC_MAX'(1))) == {SRC_MAX{1'b0}});
  endfunction

endpackage

// File: rtl/hive_alu_mux_stg.sv
// One result-pipe stage: pass-through register with taps for the sources scheduled at this stage.
module hive_alu_mux_stg
  import hive_alu_mux_pipe_pkg::*;
#(
  parameter int               ALU_W   = ALU_W_DEF,
  parameter int               FLG_W   = FLG_W_DEF,
  parameter int               SRC_N   = 6,
  parameter stg_arr_t         SRC_STG = SRC_STG_DEF,
  parameter stg_arr_t         FLG_STG = FLG_STG_DEF,
  parameter logic [SRC_N-1:0] FLG_EN  = SRC_N'(6'b100011),
  parameter logic [STG_W-1:0] STG     = 8'd0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic [SRC_N-1:0]       sel_i,
  input  logic [SRC_N*ALU_W-1:0] src_data_i,
  input  logic [SRC_N*FLG_W-1:0] src_flg_i,
  input  logic [ALU_W-1:0]       dat_i,
  input  logic [FLG_W-1:0]       flg_i,
  output logic [ALU_W-1:0]       dat_o,
  output logic [FLG_W-1:0]       flg_o
);

  logic [ALU_W-1:0] dat_nxt_s;
  logic [FLG_W-1:0] flg_nxt_s;
  logic [ALU_W-1:0] dat_r;
  logic [FLG_W-1:0] flg_r;
  logic             unused_s;

  // Sources tapped elsewhere leave parts of the shared buses unread here.
  assign unused_s = ^{sel_i, src_data_i, src_flg_i};

  // Tap the selected source when it lands here; non-flag sources clear the flags once
  always_comb begin
    dat_nxt_s = dat_i;
    flg_nxt_s = flg_i;
    for (int k = 0; k < SRC_N; k++) begin
      if (sel_i[k] && (stg_get(SRC_STG, k) == STG)) begin
        dat_nxt_s = src_data_i[k*ALU_W +: ALU_W];
        if (!FLG_EN[k]) begin
          flg_nxt_s = {FLG_W{1'b0}};
        end else begin
          flg_nxt_s = flg_nxt_s;
        end
      end else begin
        dat_nxt_s = dat_nxt_s;
      end
      if (sel_i[k] && FLG_EN[k] && (stg_get(FLG_STG, k) == STG)) begin
        flg_nxt_s = src_flg_i[k*FLG_W +: FLG_W];
      end else begin
        flg_nxt_s = flg_nxt_s;
      end
    end
  end

  // Stage register, frozen while the pipe is stalled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dat_r <= {ALU_W{1'b0}};
      flg_r <= {FLG_W{1'b0}};
    end else if (en_i) begin
      dat_r <= dat_nxt_s;
      flg_r <= flg_nxt_s;
    end
  end

  assign dat_o = dat_r;
  assign flg_o = flg_r;

endmodule

// File: rtl/hive_alu_mux_pipe.sv
// Stallable ALU result mux: a one-hot select travels with the op and each source merges at its own stage.
module hive_alu_mux_pipe
  import hive_alu_mux_pipe_pkg::*;
#(
  parameter int               ALU_W   = ALU_W_DEF,
  parameter int               FLG_W   = FLG_W_DEF,
  parameter int               SRC_N   = 6,
  parameter int               DEPTH   = 6,
  parameter stg_arr_t         SRC_STG = SRC_STG_DEF,
  parameter stg_arr_t         FLG_STG = FLG_STG_DEF,
  parameter logic [SRC_N-1:0] FLG_EN  = SRC_N'(6'b100011),
  parameter int               CNT_W   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   vld_i,
  input  logic [SRC_N-1:0]       sel_i,
  input  logic [SRC_N*ALU_W-1:0] src_data_i,
  input  logic [SRC_N*FLG_W-1:0] src_flg_i,
  input  logic                   err_clr_i,
  output logic [ALU_W-1:0]       result_o,
  output logic [FLG_W-1:0]       flg_o,
  output logic                   vld_o,
  output logic                   err_o,
  output logic [CNT_W-1:0]       err_cnt_o
);

  logic [SRC_N-1:0] sel0_s;
  logic             sel_err_s;
  logic [SRC_N-1:0] sel_stg_s [0:DEPTH-1];
  logic [SRC_N-1:0] sel_r     [1:DEPTH];
  logic [DEPTH:1]   vld_r;
  logic [ALU_W-1:0] dat_s     [0:DEPTH];
  logic [FLG_W-1:0] flg_s     [0:DEPTH];
  logic             err_r;
  logic [CNT_W-1:0] err_cnt_r;

  for (genvar k = 0; k < SRC_N; k++) begin : g_chk
    if (stg_get(SRC_STG, k) >= STG_W'(DEPTH)) begin : g_src_rng
      $error("hive_alu_mux_pipe: SRC_STG entry must be below DEPTH");
    end
    if (stg_get(FLG_STG, k) < stg_get(SRC_STG, k)) begin : g_flg_early
      $error("hive_alu_mux_pipe: FLG_STG entry precedes its SRC_STG entry");
    end
    if (stg_get(FLG_STG, k) > STG_W'(DEPTH)) begin : g_flg_rng
      $error("hive_alu_mux_pipe: FLG_STG entry beyond DEPTH");
    end
  end
  if ((SRC_N < 2) || (DEPTH < 2) || (SRC_N > SRC_MAX)) begin : g_dim_chk
    $error("hive_alu_mux_pipe: SRC_N/DEPTH out of range");
  end

  // Highest set bit wins; an empty select falls back to the default source
  always_comb begin
    sel0_s = SRC_N'(1);
    for (int k = 0; k < SRC_N; k++) begin
      sel0_s = sel_i[k] ? (SRC_N'(1) << k) : sel0_s;
    end
    sel_err_s = en_i & vld_i & ~onehot_chk(SRC_MAX'(sel_i));
  end

  // Select/valid delay line alongside the data stages
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 1; s <= DEPTH; s++) begin
        sel_r[s] <= {SRC_N{1'b0}};
      end
      vld_r <= {DEPTH{1'b0}};
    end else if (en_i) begin
      sel_r[1] <= sel0_s;
      vld_r[1] <= vld_i;
      for (int s = 2; s <= DEPTH; s++) begin
        sel_r[s] <= sel_r[s-1];
        vld_r[s] <= vld_r[s-1];
      end
    end
  end

  // Sticky error flag and saturating counter; a clear coinciding with an error restarts at one
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_r     <= 1'b0;
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (en_i) begin
      if (err_clr_i) begin
        err_r     <= sel_err_s;
        err_cnt_r <= sel_err_s ? CNT_W'(1) : {CNT_W{1'b0}};
      end else if (sel_err_s) begin
        err_r <= 1'b1;
        if (err_cnt_r != {CNT_W{1'b1}}) begin
          err_cnt_r <= err_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign sel_stg_s[0] = sel0_s;
  for (genvar s = 1; s < DEPTH; s++) begin : g_sel
    assign sel_stg_s[s] = sel_r[s];
  end

  assign dat_s[0] = {ALU_W{1'b0}};
  assign flg_s[0] = {FLG_W{1'b0}};

  for (genvar s = 0; s < DEPTH; s++) begin : g_stg
    hive_alu_mux_stg #(
      .ALU_W  (ALU_W),
      .FLG_W  (FLG_W),
      .SRC_N  (SRC_N),
      .SRC_STG(SRC_STG),
      .FLG_STG(FLG_STG),
      .FLG_EN (FLG_EN),
      .STG    (STG_W'(s))
    ) u_stg (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .en_i      (en_i),
      .sel_i     (sel_stg_s[s]),
      .src_data_i(src_data_i),
      .src_flg_i (src_flg_i),
      .dat_i     (dat_s[s]),
      .flg_i     (flg_s[s]),
      .dat_o     (dat_s[s+1]),
      .flg_o     (flg_s[s+1])
    );
  end

  // Sources whose flags arrive at the output stage bypass the flag register
  always_comb begin
    flg_o = flg_s[DEPTH];
    for (int k = 0; k < SRC_N; k++) begin
      flg_o = (sel_r[DEPTH][k] && FLG_EN[k] && (stg_get(FLG_STG, k) == STG_W'(DEPTH)))
              ? src_flg_i[k*FLG_W +: FLG_W] : flg_o;
    end
  end

  assign result_o  = dat_s[DEPTH];
  assign vld_o     = vld_r[DEPTH];
  assign err_o     = err_r;
  assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_hive_alu_mux_pipe.sv
// Directed bench for hive_alu_mux_pipe: a default instance plus a 2-bit error-counter instance.
module tb_hive_alu_mux_pipe;

  localparam int SSTG [0:5] = '{3, 3, 3, 3, 4, 5};
  localparam int FSTG [0:5] = '{3, 3, 3, 3, 4, 6};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         vld = 1'b0;
  logic         err_clr = 1'b0;
  logic [5:0]   sel = 6'd0;
  logic [191:0] src_data = 192'd0;
  logic [23:0]  src_flg = 24'd0;

  logic [31:0] result, result2;
  logic [3:0]  flg, flg2;
  logic        vld_out, vld_out2, err, err2;
  logic [7:0]  cnt;
  logic [1:0]  cnt2;

  // Ops indexed by age in enabled cycles since issue
  logic [5:0]  h_sel [0:6];
  int          h_src [0:6];
  logic [31:0] h_dat [0:6];
  logic [3:0]  h_flg [0:6];
  logic        h_vld [0:6];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hive_alu_mux_pipe u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .vld_i(vld), .sel_i(sel),
    .src_data_i(src_data), .src_flg_i(src_flg), .err_clr_i(err_clr),
    .result_o(result), .flg_o(flg), .vld_o(vld_out), .err_o(err), .err_cnt_o(cnt)
  );

  hive_alu_mux_pipe #(.CNT_W(2)) u_dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .vld_i(vld), .sel_i(sel),
    .src_data_i(src_data), .src_flg_i(src_flg), .err_clr_i(err_clr),
    .result_o(result2), .flg_o(flg2), .vld_o(vld_out2), .err_o(err2), .err_cnt_o(cnt2)
  );

  // Present each source's data/flags when the op that selected it reaches that source's stage.
  task automatic drive();
    sel = h_sel[0];
    vld = h_vld[0];
    for (int k = 0; k < 6; k++) begin
      src_data[k*32 +: 32] = (h_src[SSTG[k]] == k) ? h_dat[SSTG[k]] : (32'hBAD0_0000 | 32'(k));
      src_flg[k*4 +: 4]    = (h_src[FSTG[k]] == k) ? h_flg[FSTG[k]] : 4'hF;
    end
  endtask

  task automatic clear_hist();
    for (int a = 0; a <= 6; a++) begin
      h_sel[a] = 6'd0; h_src[a] = 0; h_dat[a] = 32'd0; h_flg[a] = 4'd0; h_vld[a] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (en) begin
      for (int a = 6; a > 0; a--) begin
        h_sel[a] = h_sel[a-1]; h_src[a] = h_src[a-1]; h_dat[a] = h_dat[a-1];
        h_flg[a] = h_flg[a-1]; h_vld[a] = h_vld[a-1];
      end
      h_sel[0] = 6'd0; h_src[0] = 0; h_dat[0] = 32'd0; h_flg[0] = 4'd0; h_vld[0] = 1'b0;
    end
    #1;
    drive();
    #1;
  endtask

  task automatic issue(input logic [5:0] s, input int src, input logic [31:0] d,
                       input logic [3:0] f, input logic v);
    h_sel[0] = s; h_src[0] = src; h_dat[0] = d; h_flg[0] = f; h_vld[0] = v;
    drive();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_hist();
    drive();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (result !== 32'd0) $display("FAIL reset_result got %h want %h", result, 32'd0); else n_pass++;
    n_chk++; if (flg !== 4'd0) $display("FAIL reset_flg got %h want %h", flg, 4'd0); else n_pass++;
    n_chk++; if (vld_out !== 1'b0) $display("FAIL reset_vld got %b want 0", vld_out); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_chk++; if (cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", cnt); else n_pass++;
    n_chk++; if (cnt2 !== 2'd0) $display("FAIL reset_cnt2 got %0d want 0", cnt2); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_route();
    issue(6'b000100, 2, 32'hA5A5_0001, 4'h3, 1'b1);
    repeat (5) tick();
    n_chk++; if (vld_out !== 1'b0) $display("FAIL src2_early_vld got %b want 0", vld_out); else n_pass++;
    tick();
    n_chk++; if (result !== 32'hA5A5_0001) $display("FAIL src2_result got %h want %h", result, 32'hA5A5_0001); else n_pass++;
    n_chk++; if (flg !== 4'h0) $display("FAIL src2_flg_forced got %h want %h", flg, 4'h0); else n_pass++;
    n_chk++; if (vld_out !== 1'b1) $display("FAIL src2_vld got %b want 1", vld_out); else n_pass++;
    issue(6'b100000, 5, 32'h1234_5678, 4'h9, 1'b1);
    repeat (6) tick();
    n_chk++; if (result !== 32'h1234_5678) $display("FAIL src5_result got %h want %h", result, 32'h1234_5678); else n_pass++;
    n_chk++; if (flg !== 4'h9) $display("FAIL src5_flg_bypass got %h want %h", flg, 4'h9); else n_pass++;
    tick();
    n_chk++; if (flg !== 4'h0) $display("FAIL bubble_flg got %h want %h", flg, 4'h0); else n_pass++;
    n_chk++; if (vld_out !== 1'b0) $display("FAIL bubble_vld got %b want 0", vld_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue(6'b000001, 0, 32'h1111_0000, 4'h5, 1'b1); tick();
    issue(6'b010000, 4, 32'h2222_0000, 4'h7, 1'b1); tick();
    issue(6'b000010, 1, 32'h3333_0000, 4'h6, 1'b1); tick();
    repeat (3) tick();
    n_chk++; if (result !== 32'h1111_0000) $display("FAIL b2b_src0_result got %h want %h", result, 32'h1111_0000); else n_pass++;
    n_chk++; if (flg !== 4'h5) $display("FAIL b2b_src0_flg got %h want %h", flg, 4'h5); else n_pass++;
    tick();
    n_chk++; if (result !== 32'h2222_0000) $display("FAIL b2b_src4_result got %h want %h", result, 32'h2222_0000); else n_pass++;
    n_chk++; if (flg !== 4'h0) $display("FAIL b2b_src4_flg got %h want %h", flg, 4'h0); else n_pass++;
    n_chk++; if (vld_out !== 1'b1) $display("FAIL b2b_src4_vld got %b want 1", vld_out); else n_pass++;
    tick();
    n_chk++; if (result !== 32'h3333_0000) $display("FAIL b2b_src1_result got %h want %h", result, 32'h3333_0000); else n_pass++;
    n_chk++; if (flg !== 4'h6) $display("FAIL b2b_src1_flg got %h want %h", flg, 4'h6); else n_pass++;
  endtask

  task automatic test_stall();
    issue(6'b000010, 1, 32'h4444_0000, 4'h2, 1'b1); tick();
    issue(6'b000001, 0, 32'h5555_0000, 4'h8, 1'b1);
    repeat (4) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (vld_out !== 1'b0) $display("FAIL stall_vld_%0d got %b want 0", i, vld_out); else n_pass++;
    end
    en = 1'b1;
    tick();
    n_chk++; if (result !== 32'h4444_0000) $display("FAIL stall_d_result got %h want %h", result, 32'h4444_0000); else n_pass++;
    n_chk++; if (vld_out !== 1'b1) $display("FAIL stall_d_vld got %b want 1", vld_out); else n_pass++;
    tick();
    n_chk++; if (result !== 32'h5555_0000) $display("FAIL stall_e_result got %h want %h", result, 32'h5555_0000); else n_pass++;
    en = 1'b0;
    tick();
    n_chk++; if (result !== 32'h5555_0000) $display("FAIL hold_result got %h want %h", result, 32'h5555_0000); else n_pass++;
    n_chk++; if (flg !== 4'h8) $display("FAIL hold_flg got %h want %h", flg, 4'h8); else n_pass++;
    en = 1'b1;
  endtask

  task automatic test_sel_err();
    issue(6'b010010, 4, 32'hCAFE_0004, 4'h1, 1'b1); tick();
    n_chk++; if (err !== 1'b1) $display("FAIL selerr_err got %b want 1", err); else n_pass++;
    n_chk++; if (cnt !== 8'd1) $display("FAIL selerr_cnt got %0d want 1", cnt); else n_pass++;
    issue(6'b010010, 4, 32'hDEAD_0004, 4'h1, 1'b0); tick();
    n_chk++; if (cnt !== 8'd1) $display("FAIL selerr_invalid_cnt got %0d want 1", cnt); else n_pass++;
    repeat (4) tick();
    n_chk++; if (result !== 32'hCAFE_0004) $display("FAIL selerr_result got %h want %h", result, 32'hCAFE_0004); else n_pass++;
    n_chk++; if (flg !== 4'h0) $display("FAIL selerr_flg got %h want %h", flg, 4'h0); else n_pass++;
    tick();
    n_chk++; if (result !== 32'hDEAD_0004) $display("FAIL invalid_result got %h want %h", result, 32'hDEAD_0004); else n_pass++;
    n_chk++; if (vld_out !== 1'b0) $display("FAIL invalid_vld got %b want 0", vld_out); else n_pass++;
  endtask

  task automatic test_saturate();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_chk++; if (err !== 1'b0) $display("FAIL clr_err got %b want 0", err); else n_pass++;
    n_chk++; if (cnt2 !== 2'd0) $display("FAIL clr_cnt2 got %0d want 0", cnt2); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      issue(6'b000011, 1, 32'h6600_0000 | 32'(i), 4'h4, 1'b1);
      tick();
    end
    n_chk++; if (cnt !== 8'd5) $display("FAIL sat_cnt8 got %0d want 5", cnt); else n_pass++;
    n_chk++; if (cnt2 !== 2'd3) $display("FAIL sat_cnt2 got %0d want 3", cnt2); else n_pass++;
    n_chk++; if (err2 !== 1'b1) $display("FAIL sat_err2 got %b want 1", err2); else n_pass++;
    err_clr = 1'b1;
    issue(6'b000011, 1, 32'h6666_0001, 4'hC, 1'b1);
    tick();
    err_clr = 1'b0;
    n_chk++; if (err !== 1'b1) $display("FAIL clr_err_same got %b want 1", err); else n_pass++;
    n_chk++; if (cnt !== 8'd1) $display("FAIL clr_cnt_same got %0d want 1", cnt); else n_pass++;
    n_chk++; if (cnt2 !== 2'd1) $display("FAIL clr_cnt2_same got %0d want 1", cnt2); else n_pass++;
    repeat (5) tick();
    n_chk++; if (result !== 32'h6666_0001) $display("FAIL hi_wins_result got %h want %h", result, 32'h6666_0001); else n_pass++;
    n_chk++; if (flg !== 4'hC) $display("FAIL hi_wins_flg got %h want %h", flg, 4'hC); else n_pass++;
  endtask

  task automatic test_async_reset();
    issue(6'b001001, 3, 32'h7777_0000, 4'h3, 1'b1); tick();
    issue(6'b000001, 0, 32'h7777_0001, 4'h1, 1'b1); tick();
    repeat (4) tick();
    n_chk++; if (result !== 32'h7777_0000) $display("FAIL prerst_result got %h want %h", result, 32'h7777_0000); else n_pass++;
    n_chk++; if (err !== 1'b1) $display("FAIL prerst_err got %b want 1", err); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (result !== 32'd0) $display("FAIL arst_result got %h want %h", result, 32'd0); else n_pass++;
    n_chk++; if (vld_out !== 1'b0) $display("FAIL arst_vld got %b want 0", vld_out); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL arst_err got %b want 0", err); else n_pass++;
    n_chk++; if (cnt !== 8'd0) $display("FAIL arst_cnt got %0d want 0", cnt); else n_pass++;
    clear_hist();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    issue(6'b000001, 0, 32'h8888_0001, 4'hA, 1'b1);
    repeat (5) tick();
    n_chk++; if (vld_out !== 1'b0) $display("FAIL postrst_early_vld got %b want 0", vld_out); else n_pass++;
    tick();
    n_chk++; if (result !== 32'h8888_0001) $display("FAIL postrst_result got %h want %h", result, 32'h8888_0001); else n_pass++;
    n_chk++; if (flg !== 4'hA) $display("FAIL postrst_flg got %h want %h", flg, 4'hA); else n_pass++;
    n_chk++; if (vld_out !== 1'b1) $display("FAIL postrst_vld got %b want 1", vld_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_route();
    test_back_to_back();
    test_stall();
    test_sel_err();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
